// File: rtl/snn_result_streamer_if.sv
// Result-side output channels of the SNN streamer: six valid/ready token
// channels sharing one direction. The streamer is the master.
interface snn_result_streamer_if #(
  parameter int WIDTH_ADDR = 12,
  parameter int WIDTH_DATA = 13
);
  logic                  start_r_valid, start_r_ready, start_r;
  logic                  ts_r_valid, ts_r_ready;
  logic [1:0]            ts_r;
  logic                  layer_r_valid, layer_r_ready;
  logic [1:0]            layer_r;
  logic                  out_spike_addr_valid, out_spike_addr_ready;
  logic [WIDTH_ADDR-1:0] out_spike_addr;
  logic                  out_spike_data_valid, out_spike_data_ready;
  logic [WIDTH_DATA-1:0] out_spike_data;
  logic                  done_r_valid, done_r_ready, done_r;

  modport master (
    output start_r_valid, start_r, ts_r_valid, ts_r, layer_r_valid, layer_r,
           out_spike_addr_valid, out_spike_addr, out_spike_data_valid,
           out_spike_data, done_r_valid, done_r,
    input  start_r_ready, ts_r_ready, layer_r_ready, out_spike_addr_ready,
           out_spike_data_ready, done_r_ready
  );

  modport slave (
    input  start_r_valid, start_r, ts_r_valid, ts_r, layer_r_valid, layer_r,
           out_spike_addr_valid, out_spike_addr, out_spike_data_valid,
           out_spike_data, done_r_valid, done_r,
    output start_r_ready, ts_r_ready, layer_r_ready, out_spike_addr_ready,
           out_spike_data_ready, done_r_ready
  );
endinterface

// File: rtl/snn_result_streamer.sv
// Buffers per-timestep output-spike words and streams them as
// start, {ts, layer, (addr, data) x DEPTH_R^2} x NUM_TS, done.
// Storage is a plain RAM plus per-entry written bits; only the bits are
// reset, so an unwritten entry reads back as zero after any reset.
module snn_result_streamer #(
  parameter int WIDTH_ADDR = 12,
  parameter int WIDTH_DATA = 13,
  parameter int DEPTH_R    = 21,
  parameter int NUM_TS     = 2,
  parameter int LAYER_ID   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [1:0]            wr_ts,
  input  logic [WIDTH_ADDR-1:0] wr_addr,
  input  logic [WIDTH_DATA-1:0] wr_data,
  input  logic                  ts_done,
  input  logic [1:0]            ts_done_ts,
  snn_result_streamer_if.master res
);
  localparam int N       = DEPTH_R * DEPTH_R;
  localparam int ENTRIES = NUM_TS * N;
  localparam int MW      = $clog2(ENTRIES);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_TS    = 4'd2;
  localparam logic [3:0] S_LAYER = 4'd3;
  localparam logic [3:0] S_RD    = 4'd4;
  localparam logic [3:0] S_ADDR  = 4'd5;
  localparam logic [3:0] S_DATA  = 4'd6;
  localparam logic [3:0] S_WAIT  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [3:0] S_FIN   = 4'd9;

  logic [WIDTH_DATA-1:0] mem [ENTRIES];
  logic [ENTRIES-1:0]    wvld;
  logic [NUM_TS-1:0]     closed, closed_nxt;
  logic                  wr_open, wr_ok, cur_closed;
  logic [MW-1:0]         wa, ra;
  logic [WIDTH_DATA-1:0] rd_q;
  logic [3:0]            state;
  logic [1:0]            cur_ts;
  logic [WIDTH_ADDR-1:0] idx;

  // Close bookkeeping and write qualification. The FSM looks at closed_nxt
  // so a close is acted on in the cycle right after the ts_done edge.
  always_comb begin
    closed_nxt = closed;
    wr_open    = 1'b0;
    cur_closed = 1'b0;
    for (int t = 0; t < NUM_TS; t++) begin
      if (ts_done && ts_done_ts == 2'(t + 1)) closed_nxt[t] = 1'b1;
      if (wr_ts == 2'(t + 1))                 wr_open       = !closed[t];
    end
    for (int t = 0; t < NUM_TS; t++)
      if (cur_ts == 2'(t + 1)) cur_closed = closed_nxt[t];
    wr_ok = wr_en && wr_open && (int'(wr_addr) < N);
    wa    = MW'((int'(wr_ts) - 1) * N + int'(wr_addr));
    ra    = MW'((int'(cur_ts) - 1) * N + int'(idx));
  end

  // Word storage, no reset: validity comes from wvld.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wa] <= wr_data;
  end

  // Written bits, close flags and the 1-cycle read register (loaded in RD,
  // then held through any DATA stall).
  always_ff @(posedge clk) begin
    if (reset) begin
      wvld   <= '0;
      closed <= '0;
      rd_q   <= '0;
    end else begin
      if (wr_ok) wvld[wa] <= 1'b1;
      closed <= closed_nxt;
      if (state == S_RD) rd_q <= wvld[ra] ? mem[ra] : '0;
    end
  end

  // Token sequencer: each output state holds until its handshake edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cur_ts <= 2'd1;
      idx    <= '0;
    end else begin
      case (state)
        S_IDLE:  if (closed_nxt[0]) state <= S_START;
        S_START: if (res.start_r_ready) begin
          state  <= S_TS;
          cur_ts <= 2'd1;
          idx    <= '0;
        end
        S_TS:    if (res.ts_r_ready)    state <= S_LAYER;
        S_LAYER: if (res.layer_r_ready) state <= S_RD;
        S_RD:    state <= S_ADDR;
        S_ADDR:  if (res.out_spike_addr_ready) state <= S_DATA;
        S_DATA:  if (res.out_spike_data_ready) begin
          if (idx != WIDTH_ADDR'(N - 1)) begin
            idx   <= idx + WIDTH_ADDR'(1);
            state <= S_RD;
          end else if (int'(cur_ts) < NUM_TS) begin
            cur_ts <= cur_ts + 2'd1;
            idx    <= '0;
            state  <= S_WAIT;
          end else begin
            state <= S_DONE;
          end
        end
        S_WAIT:  if (cur_closed) state <= S_TS;
        S_DONE:  if (res.done_r_ready) state <= S_FIN;
        S_FIN:   state <= S_FIN;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Channel outputs decoded from state; payloads are zero when not valid.
  always_comb begin
    res.start_r_valid        = (state == S_START);
    res.start_r              = (state == S_START);
    res.ts_r_valid           = (state == S_TS);
    res.ts_r                 = (state == S_TS) ? cur_ts : 2'd0;
    res.layer_r_valid        = (state == S_LAYER);
    res.layer_r              = (state == S_LAYER) ? 2'(LAYER_ID) : 2'd0;
    res.out_spike_addr_valid = (state == S_ADDR);
    res.out_spike_addr       = (state == S_ADDR) ? idx : '0;
    res.out_spike_data_valid = (state == S_DATA);
    res.out_spike_data       = (state == S_DATA) ? rd_q : '0;
    res.done_r_valid         = (state == S_DONE);
    res.done_r               = (state == S_DONE);
  end
endmodule

// File: tb/tb_snn_result_streamer.sv
// Bench for snn_result_streamer: a token-level model (per-timestep arrays
// and close flags) produces the expected stream; a monitor captures every
// handshaked token and tracks one-hot-valid and hold-while-stalled rules.
module tb_snn_result_streamer;
  localparam int N   = 441;
  localparam int NTS = 2;
  localparam int TOT = 1 + NTS * (2 + 2 * N) + 1;

  logic        clk = 1'b0;
  logic        reset, wr_en, ts_done;
  logic [1:0]  wr_ts, ts_done_ts;
  logic [11:0] wr_addr;
  logic [12:0] wr_data;

  snn_result_streamer_if #(.WIDTH_ADDR(12), .WIDTH_DATA(13)) res ();

  snn_result_streamer #(.WIDTH_ADDR(12), .WIDTH_DATA(13), .DEPTH_R(21),
                        .NUM_TS(2), .LAYER_ID(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ts(wr_ts), .wr_addr(wr_addr),
    .wr_data(wr_data), .ts_done(ts_done), .ts_done_ts(ts_done_ts), .res(res)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int val; } tok_t;  // ch: 0 start,1 ts,2 layer,3 addr,4 data,5 done

  int   checks = 0, errors = 0;
  int   m [1:NTS][0:N-1];
  bit   mclosed [1:NTS];
  tok_t got[$], exp_q[$];
  int   cyc = 0, start_cyc, done_cyc, multi_err, stab_err;
  bit   rand_rdy = 0, pend = 0;
  tok_t pend_tok;

  // Ready driver: all high, or independent coin flips per channel.
  initial begin
    {res.start_r_ready, res.ts_r_ready, res.layer_r_ready,
     res.out_spike_addr_ready, res.out_spike_data_ready, res.done_r_ready} = 6'h3f;
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) begin
        res.start_r_ready        = 1'($urandom_range(0, 1));
        res.ts_r_ready           = 1'($urandom_range(0, 1));
        res.layer_r_ready        = 1'($urandom_range(0, 1));
        res.out_spike_addr_ready = 1'($urandom_range(0, 1));
        res.out_spike_data_ready = 1'($urandom_range(0, 1));
        res.done_r_ready         = 1'($urandom_range(0, 1));
      end else begin
        {res.start_r_ready, res.ts_r_ready, res.layer_r_ready,
         res.out_spike_addr_ready, res.out_spike_data_ready, res.done_r_ready} = 6'h3f;
      end
    end
  end

  // Monitor on the falling edge: capture handshakes, track protocol rules.
  initial begin
    forever begin
      int   nv;
      bit   r;
      tok_t t;
      @(negedge clk);
      cyc++;
      nv = 0; r = 0; t = '{-1, 0};
      if (res.start_r_valid)        begin nv++; t = '{0, int'(res.start_r)};        r = res.start_r_ready;        end
      if (res.ts_r_valid)           begin nv++; t = '{1, int'(res.ts_r)};           r = res.ts_r_ready;           end
      if (res.layer_r_valid)        begin nv++; t = '{2, int'(res.layer_r)};        r = res.layer_r_ready;        end
      if (res.out_spike_addr_valid) begin nv++; t = '{3, int'(res.out_spike_addr)}; r = res.out_spike_addr_ready; end
      if (res.out_spike_data_valid) begin nv++; t = '{4, int'(res.out_spike_data)}; r = res.out_spike_data_ready; end
      if (res.done_r_valid)         begin nv++; t = '{5, int'(res.done_r)};         r = res.done_r_ready;         end
      if (nv > 1) multi_err++;
      if (pend && (nv != 1 || t.ch != pend_tok.ch || t.val != pend_tok.val)) stab_err++;
      if (nv == 1) begin
        if (t.ch == 0 && start_cyc < 0) start_cyc = cyc;
        if (t.ch == 5 && done_cyc < 0)  done_cyc  = cyc;
        if (r) got.push_back(t);
        pend = !r; pend_tok = t;
      end else begin
        pend = 0;
      end
    end
  end

  function automatic logic [5:0] valids();
    return {res.start_r_valid, res.ts_r_valid, res.layer_r_valid,
            res.out_spike_addr_valid, res.out_spike_data_valid, res.done_r_valid};
  endfunction

  function automatic string tok_str(input tok_t q[$], input int i);
    if (i < 0 || i >= q.size()) return "none";
    return $sformatf("ch%0d=%0d", q[i].ch, q[i].val);
  endfunction

  // Expected stream straight from the token-order rules and the model arrays.
  function automatic void build_exp();
    exp_q.delete();
    exp_q.push_back('{0, 1});
    for (int ts = 1; ts <= NTS; ts++) begin
      exp_q.push_back('{1, ts});
      exp_q.push_back('{2, 1});
      for (int i = 0; i < N; i++) begin
        exp_q.push_back('{3, i});
        exp_q.push_back('{4, m[ts][i]});
      end
    end
    exp_q.push_back('{5, 1});
  endfunction

  function automatic int first_diff();
    int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got[i].ch != exp_q[i].ch || got[i].val != exp_q[i].val) return i;
    if (got.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mon_clear();
    got.delete(); start_cyc = -1; done_cyc = -1; multi_err = 0; stab_err = 0;
  endtask

  task automatic model_write(int ts, int addr, int data);
    if (ts >= 1 && ts <= NTS && addr >= 0 && addr < N)
      if (!mclosed[ts]) m[ts][addr] = data;
  endtask

  task automatic do_write(int ts, int addr, int data);
    wr_en = 1; wr_ts = 2'(ts); wr_addr = 12'(addr); wr_data = 13'(data);
    tick();
    wr_en = 0;
    model_write(ts, addr, data);
  endtask

  task automatic do_close(int ts);
    ts_done = 1; ts_done_ts = 2'(ts);
    tick();
    ts_done = 0;
    if (ts >= 1 && ts <= NTS) mclosed[ts] = 1;
  endtask

  task automatic write_and_close(int ts, int addr, int data);
    wr_en = 1; wr_ts = 2'(ts); wr_addr = 12'(addr); wr_data = 13'(data);
    ts_done = 1; ts_done_ts = 2'(ts);
    tick();
    wr_en = 0; ts_done = 0;
    model_write(ts, addr, data);
    if (ts >= 1 && ts <= NTS) mclosed[ts] = 1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
    for (int ts = 1; ts <= NTS; ts++) begin
      mclosed[ts] = 0;
      for (int i = 0; i < N; i++) m[ts][i] = 0;
    end
  endtask

  task automatic load_random(int skip_one_in);
    for (int ts = 1; ts <= NTS; ts++)
      for (int i = 0; i < N; i++)
        if (skip_one_in == 0 || $urandom_range(0, skip_one_in - 1) != 0)
          do_write(ts, i, int'($urandom_range(0, 8191)));
  endtask

  task automatic wait_tokens(int n, int budget, output bit ok);
    int k = 0;
    while (got.size() < n && k < budget) begin @(negedge clk); k++; end
    ok = (got.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1; tick();
    @(negedge clk);
    checks++;
    if (valids() !== 6'b0) begin errors++; $display("FAIL reset_valids: got %b want 000000", valids()); end
    checks++;
    if ({res.start_r, res.ts_r, res.layer_r, res.out_spike_addr, res.out_spike_data, res.done_r} !== '0) begin
      errors++; $display("FAIL reset_payload: got nonzero payload, want all 0");
    end
    do_reset(); mon_clear();
    do_close(2);
    repeat (10) tick();
    checks++;
    if (got.size() !== 0 || valids() !== 6'b0) begin
      errors++; $display("FAIL no_start_without_ts1: got %0d tokens valids %b, want 0 tokens", got.size(), valids());
    end
  endtask

  task automatic test_full_stream();
    bit ok; int d;
    do_reset(); mon_clear(); rand_rdy = 0;
    for (int i = 0; i < N; i++) do_write(1, i, i);
    for (int i = 0; i < N; i++) do_write(2, i, i + 1000);
    checks++;
    if (valids() !== 6'b0) begin errors++; $display("FAIL full_pre_close: got valids %b want 000000", valids()); end
    do_close(1);
    @(negedge clk);
    checks++;
    if (res.start_r_valid !== 1'b1) begin errors++; $display("FAIL start_latency: got start_r_valid=%b want 1", res.start_r_valid); end
    do_close(2);
    wait_tokens(TOT, 4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout: got %0d tokens want %0d", got.size(), TOT); end
    build_exp();
    checks++;
    d = first_diff();
    if (d !== -1) begin
      errors++;
      $display("FAIL full_stream token %0d: got %s want %s (sizes %0d/%0d)", d, tok_str(got, d), tok_str(exp_q, d), got.size(), exp_q.size());
    end
    // start cycle S, ts1 S+1..S+1325, one WAIT cycle, ts2 S+1327..S+2651, done S+2652
    checks++;
    if (done_cyc - start_cyc !== 2652) begin
      errors++; $display("FAIL full_timing: got done-start=%0d cycles want 2652", done_cyc - start_cyc);
    end
    repeat (5) tick();
    checks++;
    if (valids() !== 6'b0 || got.size() !== TOT) begin
      errors++; $display("FAIL fin_quiet: got valids %b tokens %0d want 000000 and %0d", valids(), got.size(), TOT);
    end
  endtask

  task automatic test_random_ready();
    bit ok; int d;
    do_reset(); mon_clear();
    load_random(4);
    do_close(1); do_close(2);
    rand_rdy = 1;
    wait_tokens(TOT, 20000, ok);
    rand_rdy = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rand_timeout: got %0d tokens want %0d", got.size(), TOT); end
    build_exp();
    checks++;
    d = first_diff();
    if (d !== -1) begin
      errors++;
      $display("FAIL rand_stream token %0d: got %s want %s (sizes %0d/%0d)", d, tok_str(got, d), tok_str(exp_q, d), got.size(), exp_q.size());
    end
    checks++;
    if (multi_err !== 0) begin errors++; $display("FAIL one_valid: got %0d multi-valid cycles want 0", multi_err); end
    checks++;
    if (stab_err !== 0) begin errors++; $display("FAIL hold_stable: got %0d unstable stalls want 0", stab_err); end
  endtask

  task automatic test_wait();
    bit ok; int d;
    do_reset(); mon_clear();
    load_random(0);
    do_close(1);
    wait_tokens(3 + 2 * N, 4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_ts1_timeout: got %0d tokens want %0d", got.size(), 3 + 2 * N); end
    repeat (500) tick();
    checks++;
    if (got.size() !== 3 + 2 * N || valids() !== 6'b0) begin
      errors++; $display("FAIL wait_stall: got %0d tokens valids %b want %0d and 000000", got.size(), valids(), 3 + 2 * N);
    end
    do_close(2);
    @(negedge clk);
    checks++;
    if (res.ts_r_valid !== 1'b1 || res.ts_r !== 2'd2) begin
      errors++; $display("FAIL wait_resume: got ts_r_valid=%b ts_r=%0d want 1 and 2", res.ts_r_valid, res.ts_r);
    end
    wait_tokens(TOT, 4000, ok);
    build_exp();
    checks++;
    d = first_diff();
    if (d !== -1) begin
      errors++;
      $display("FAIL wait_stream token %0d: got %s want %s (sizes %0d/%0d)", d, tok_str(got, d), tok_str(exp_q, d), got.size(), exp_q.size());
    end
  endtask

  task automatic test_drop();
    bit ok; int d, v7;
    do_reset(); mon_clear();
    load_random(0);
    do_write(1, 5, 42);
    do_write(1, 441, 111);
    do_write(3, 5, 222);
    do_write(0, 5, 333);
    do_write(2, 4095, 444);
    v7 = int'($urandom_range(0, 8191));
    write_and_close(1, 7, v7);
    do_write(1, 5, 7777);
    do_close(1);
    do_close(0);
    do_close(3);
    do_close(2);
    wait_tokens(TOT, 4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_timeout: got %0d tokens want %0d", got.size(), TOT); end
    build_exp();
    checks++;
    d = first_diff();
    if (d !== -1) begin
      errors++;
      $display("FAIL drop_stream token %0d: got %s want %s (sizes %0d/%0d)", d, tok_str(got, d), tok_str(exp_q, d), got.size(), exp_q.size());
    end
    // ts1 data for index i sits at token 3 + 2*i + 1
    checks++;
    if (got.size() < 20 || got[14].val !== 42) begin
      errors++; $display("FAIL closed_write_dropped: got addr5 data %s want 42", tok_str(got, 14));
    end
    checks++;
    if (got.size() < 20 || got[18].val !== v7) begin
      errors++; $display("FAIL write_with_close: got addr7 data %s want %0d", tok_str(got, 18), v7);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int d;
    do_reset(); mon_clear();
    load_random(0);
    do_close(1); do_close(2);
    wait_tokens(3 + 2 * 200 + 1, 4000, ok);
    reset = 1;
    tick();
    @(negedge clk);
    checks++;
    if (valids() !== 6'b0) begin errors++; $display("FAIL mid_reset_valids: got %b want 000000", valids()); end
    do_reset(); mon_clear();
    repeat (10) tick();
    checks++;
    if (got.size() !== 0) begin errors++; $display("FAIL mid_reset_idle: got %0d tokens want 0", got.size()); end
    load_random(3);
    do_close(1); do_close(2);
    wait_tokens(TOT, 4000, ok);
    build_exp();
    checks++;
    d = first_diff();
    if (d !== -1) begin
      errors++;
      $display("FAIL restart_stream token %0d: got %s want %s (sizes %0d/%0d)", d, tok_str(got, d), tok_str(exp_q, d), got.size(), exp_q.size());
    end
  endtask

  initial begin
    reset = 1; wr_en = 0; wr_ts = 0; wr_addr = 0; wr_data = 0; ts_done = 0; ts_done_ts = 0;
    test_reset();
    test_full_stream();
    test_random_ready();
    test_wait();
    test_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
